// File: rtl/nes_pad_poller.sv
// nes_pad_poller: reads a native NES pad (latch, 7 or 8 clock pulses, serial data) once per poll
// and publishes an atomic active-high snapshot. Define NES_PRESENCE_DETECT_EN for a ninth presence bit.
module nes_pad_poller #(
    parameter int HALF_PERIOD = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy,
    output logic       present,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(2 * HALF_PERIOD + 1);
`ifdef NES_PRESENCE_DETECT_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int IW = $clog2(NBITS);

    localparam logic [CW-1:0] LOAD_LATCH = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] LOAD_HALF  = CW'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] LAST_BIT   = IW'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_WAIT0  = 3'd2,
        S_CLK_HI = 3'd3,
        S_CLK_LO = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     bit_q;
    logic [NBITS-1:0]  shift_q;
    logic              latch_q;
    logic              nclk_q;
    logic [7:0]        buttons_q;
    logic              valid_q;
    logic              busy_q;
`ifdef NES_PRESENCE_DETECT_EN
    logic              present_q;
`endif

    // poll is a one-cycle request, taken only in IDLE and never in the cycle valid is high;
    // valid is a one-cycle pulse with no backpressure. Pins trail the state by one register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            buttons_q <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef NES_PRESENCE_DETECT_EN
            present_q <= 1'b0;
`endif
        end else begin
            latch_q <= (state_q == S_LATCH);
            nclk_q  <= (state_q == S_CLK_HI);
            busy_q  <= (state_q inside {S_LATCH, S_WAIT0, S_CLK_HI, S_CLK_LO});
            valid_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (poll && !valid_q) begin
                        state_q <= S_LATCH;
                        cnt_q   <= LOAD_LATCH;
                        bit_q   <= '0;
                    end
                end
                S_LATCH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_WAIT0;
                        cnt_q   <= LOAD_HALF;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_WAIT0: begin
                    if (cnt_q == '0) begin
                        shift_q[0] <= nes_data;
                        bit_q      <= IW'(1);
                        state_q    <= S_CLK_HI;
                        cnt_q      <= LOAD_HALF;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_CLK_HI: begin
                    if (cnt_q == '0) begin
                        state_q <= S_CLK_LO;
                        cnt_q   <= LOAD_HALF;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_CLK_LO: begin
                    if (cnt_q == '0) begin
                        shift_q[bit_q] <= nes_data;
                        if (bit_q == LAST_BIT) begin
                            state_q <= S_DONE;
                        end else begin
                            bit_q   <= bit_q + IW'(1);
                            state_q <= S_CLK_HI;
                            cnt_q   <= LOAD_HALF;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
`ifdef NES_PRESENCE_DETECT_EN
                    buttons_q <= shift_q[NBITS-1] ? 8'h00 : ~shift_q[7:0];
                    present_q <= ~shift_q[NBITS-1];
`else
                    buttons_q <= ~shift_q[7:0];
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign nes_latch = latch_q;
    assign nes_clk   = nclk_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
`ifdef NES_PRESENCE_DETECT_EN
    assign present   = present_q;
`else
    assign present   = 1'b1;
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller at HALF_PERIOD=4: pad emulation, timeline model of the pins,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_nes_pad_poller;

  localparam int H = 4;
`ifdef NES_PRESENCE_DETECT_EN
  localparam int T        = 19 * H + 1;
  localparam int LAT_LIT  = 77;
  localparam int NPULSE   = 8;
  localparam logic PRES_RST = 1'b0;
`else
  localparam int T        = 17 * H + 1;
  localparam int LAT_LIT  = 69;
  localparam int NPULSE   = 7;
  localparam logic PRES_RST = 1'b1;
`endif

  logic       clk;
  logic       reset;
  logic       poll;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;
  logic       present;
  logic [2:0] dbg_state;

  nes_pad_poller #(.HALF_PERIOD(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .poll      (poll),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy),
    .present   (present),
    .dbg_state (dbg_state)
  );

  // clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // pad emulation: latch loads, each nes_clk rise shifts; grounded serial input after 8 bits
  logic [7:0] pad_pressed;
  logic       pad_connected;
  int         pad_idx = 0;
  always @(posedge nes_latch) pad_idx = 0;
  always @(posedge nes_clk) pad_idx = pad_idx + 1;
  always_comb begin
    nes_data = 1'b1;
    if (pad_connected) begin
      if (pad_idx < 8) nes_data = ~pad_pressed[pad_idx[2:0]];
      else nes_data = 1'b0;
    end
  end

  // scoreboard counters
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // timeline model: k counts edges since the accepted poll
  int         m_active = 0;
  int         m_k = 0;
  logic [7:0] m_buttons;
  logic       m_present;
  logic [7:0] m_snap_pressed;
  logic       m_snap_conn;

  always @(posedge clk) begin
    if (reset) begin
      m_active  = 0;
      m_k       = 0;
      m_buttons = 8'h00;
      m_present = PRES_RST;
    end else if (m_active != 0) begin
      m_k = m_k + 1;
      if (m_k == T) begin
        m_buttons = m_snap_conn ? m_snap_pressed : 8'h00;
`ifdef NES_PRESENCE_DETECT_EN
        m_present = m_snap_conn;
`else
        m_present = 1'b1;
`endif
      end
      if (m_k == T + 1) m_active = 0;
    end else if (poll) begin
      m_active       = 1;
      m_k            = 0;
      m_snap_pressed = pad_pressed;
      m_snap_conn    = pad_connected;
    end
  end

  // per-cycle compare against the model
  logic check_en = 1'b0;
  always @(negedge clk) begin
    logic e_latch, e_clk, e_busy, e_valid, e_present;
    logic [7:0] e_buttons;
    if (check_en) begin
      if (reset) begin
        e_latch = 0; e_clk = 0; e_busy = 0; e_valid = 0;
        e_buttons = 8'h00; e_present = PRES_RST;
      end else begin
        e_latch   = (m_active != 0) && m_k >= 1 && m_k <= 2 * H;
        e_busy    = (m_active != 0) && m_k >= 1 && m_k <= T - 1;
        e_clk     = (m_active != 0) && m_k >= 3 * H + 1 && m_k <= T - 1
                    && (((m_k - 3 * H - 1) / H) % 2 == 0);
        e_valid   = (m_active != 0) && m_k == T;
        e_buttons = m_buttons;
        e_present = m_present;
      end
      check("cyc_nes_latch", {31'd0, nes_latch}, {31'd0, e_latch});
      check("cyc_nes_clk",   {31'd0, nes_clk},   {31'd0, e_clk});
      check("cyc_busy",      {31'd0, busy},      {31'd0, e_busy});
      check("cyc_valid",     {31'd0, valid},     {31'd0, e_valid});
      check("cyc_buttons",   {24'd0, buttons},   {24'd0, e_buttons});
      check("cyc_present",   {31'd0, present},   {31'd0, e_present});
    end
  end

  // pin-shape monitor (sole writer of these totals)
  int   lat_hi_tot = 0;
  int   clk_hi_tot = 0;
  int   overlap_tot = 0;
  int   valid_tot = 0;
  int   pulses_since_latch = 0;
  int   last_latch_hi = 0;
  int   first_clk = 0;
  logic clk_prev = 1'b0;
  always @(negedge clk) begin
    if (nes_latch === 1'b1) begin
      lat_hi_tot = lat_hi_tot + 1;
      last_latch_hi = cyc;
      pulses_since_latch = 0;
    end
    if (nes_clk === 1'b1) begin
      clk_hi_tot = clk_hi_tot + 1;
      if (!clk_prev) begin
        if (pulses_since_latch == 0) first_clk = cyc;
        pulses_since_latch = pulses_since_latch + 1;
      end
    end
    if (nes_latch === 1'b1 && nes_clk === 1'b1) overlap_tot = overlap_tot + 1;
    if (valid === 1'b1) valid_tot = valid_tot + 1;
    clk_prev = (nes_clk === 1'b1);
  end

  // driver tasks
  task automatic do_poll(output int p);
    @(negedge clk);
    poll = 1'b1;
    p = cyc + 1;
    @(negedge clk);
    poll = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int v);
    v = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        v = cyc;
        break;
      end
    end
    if (v < 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  int p, p2, v;
  int s_lat, s_clkhi, s_ovl, s_val;

  initial begin
    poll = 1'b0;
    reset = 1'b0;
    pad_pressed = 8'h81;
    pad_connected = 1'b1;
    #3 reset = 1'b1;
    #1 check_en = 1'b1;
    check("rst_latch",   {31'd0, nes_latch}, 32'd0);
    check("rst_clk",     {31'd0, nes_clk},   32'd0);
    check("rst_buttons", {24'd0, buttons},   32'd0);
    check("rst_valid",   {31'd0, valid},     32'd0);
    check("rst_busy",    {31'd0, busy},      32'd0);
    check("rst_present", {31'd0, present},   {31'd0, PRES_RST});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // A and right pressed: latency, snapshot, pin shape
    s_lat = lat_hi_tot; s_clkhi = clk_hi_tot; s_ovl = overlap_tot; s_val = valid_tot;
    do_poll(p);
    wait_valid(T + 20, v);
    check("latency_81", v - p, LAT_LIT);
    check("buttons_81", {24'd0, buttons}, 32'h81);
    check("present_81", {31'd0, present}, 32'd1);
    repeat (3) @(negedge clk);
    check("latch_hi_cycles", lat_hi_tot - s_lat, 32'd8);
    check("clk_hi_cycles",   clk_hi_tot - s_clkhi, 4 * NPULSE);
    check("clk_pulses",      pulses_since_latch, NPULSE);
    check("latch_clk_gap",   first_clk - last_latch_hi, 32'd5);
    check("overlap",         overlap_tot - s_ovl, 32'd0);
    check("valid_pulses_A",  valid_tot - s_val, 32'd1);

    // second poll mid-read and poll in the valid cycle are both dropped
    s_val = valid_tot;
    do_poll(p);
    while (cyc < p + 9) @(negedge clk);
    poll = 1'b1;
    @(negedge clk);
    poll = 1'b0;
    wait_valid(T + 20, v);
    check("latency_dbl", v - p, LAT_LIT);
    poll = 1'b1;
    @(negedge clk);
    poll = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_after_done_poll", {31'd0, busy}, 32'd0);
    check("valid_pulses_B", valid_tot - s_val, 32'd1);
    do_poll(p2);
    wait_valid(T + 20, v);
    check("latency_new", v - p2, LAT_LIT);
    check("buttons_new", {24'd0, buttons}, 32'h81);

    // no pad: line pulled high
    pad_connected = 1'b0;
    do_poll(p);
    wait_valid(T + 20, v);
    check("buttons_absent", {24'd0, buttons}, 32'h00);
`ifdef NES_PRESENCE_DETECT_EN
    check("present_absent", {31'd0, present}, 32'd0);
`else
    check("present_absent", {31'd0, present}, 32'd1);
`endif

    // another pattern
    pad_connected = 1'b1;
    pad_pressed = 8'h5A;
    do_poll(p);
    wait_valid(T + 20, v);
    check("buttons_5a", {24'd0, buttons}, 32'h5A);
    check("present_5a", {31'd0, present}, 32'd1);

    // asynchronous reset in the middle of a read
    pad_pressed = 8'h81;
    do_poll(p);
    while (cyc < p + 30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_latch",   {31'd0, nes_latch}, 32'd0);
    check("mid_rst_clk",     {31'd0, nes_clk},   32'd0);
    check("mid_rst_busy",    {31'd0, busy},      32'd0);
    check("mid_rst_valid",   {31'd0, valid},     32'd0);
    check("mid_rst_buttons", {24'd0, buttons},   32'h00);
    check("mid_rst_present", {31'd0, present},   {31'd0, PRES_RST});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    s_val = valid_tot;
    repeat (T + 10) @(negedge clk);
    check("valid_after_rst", valid_tot - s_val, 32'd0);
    do_poll(p);
    wait_valid(T + 20, v);
    check("latency_post_rst", v - p, LAT_LIT);
    check("buttons_post_rst", {24'd0, buttons}, 32'h81);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
